// File: rtl/ula_pkg.sv
// Shared constants and state encoding for the ALU result-bus sequencer.
package ula_pkg;
  localparam int OP_W   = 3;
  localparam int DATA_W = 8;
  localparam int BUS_W  = 9;
  localparam int CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;
endpackage

// File: rtl/ula_if.sv
// Request, unit-side and response signals of the sequencer; master is the sequencer side.
interface ula_if #(parameter int NUM_UNITS = 8);
  import ula_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      in_op;
  logic [DATA_W-1:0]    in_a;
  logic [DATA_W-1:0]    in_b;
  logic [DATA_W-1:0]    op_a;
  logic [DATA_W-1:0]    op_b;
  logic [NUM_UNITS-1:0] unit_en;
  logic [BUS_W-1:0]     bus;
  logic                 out_valid;
  logic                 out_ready;
  logic [BUS_W-1:0]     out_result;
  logic                 out_zero;
  logic                 out_carry;
  logic                 out_err;

  modport master (
    input  in_valid, in_op, in_a, in_b, bus, out_ready,
    output in_ready, op_a, op_b, unit_en, out_valid, out_result, out_zero, out_carry, out_err
  );

  modport slave (
    output in_valid, in_op, in_a, in_b, bus, out_ready,
    input  in_ready, op_a, op_b, unit_en, out_valid, out_result, out_zero, out_carry, out_err
  );
endinterface

// File: rtl/ula_en_decoder.sv
// Opcode to one-hot unit enable; reserved or unpopulated opcodes decode to no enable.
module ula_en_decoder
  import ula_pkg::*;
#(
  parameter int NUM_UNITS = 8
) (
  input  logic [OP_W-1:0]      op_i,
  output logic [NUM_UNITS-1:0] en_o,
  output logic                 legal_o
);
  always_comb begin
    legal_o = (op_i <= OP_NOT) && (int'(op_i) < NUM_UNITS);
    en_o    = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      en_o[i] = legal_o && (int'(op_i) == i);
    end
  end
endmodule

// File: rtl/ula_sequencer.sv
// Shared ALU bus sequencer: accept op, enable one unit for SETTLE cycles, capture bus, respond.
module ula_sequencer
  import ula_pkg::*;
#(
  parameter int NUM_UNITS = 8,
  parameter int SETTLE    = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  ula_if.master u
);
  state_e               state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_UNITS-1:0] en_q, en_d, en_next;
  logic [BUS_W-1:0]     res_q, res_d;
  logic                 zero_q, zero_d, carry_q, carry_d, err_q, err_d;
  logic                 legal, accept;

  ula_en_decoder #(.NUM_UNITS(NUM_UNITS)) u_dec (
    .op_i    (u.in_op),
    .en_o    (en_next),
    .legal_o (legal)
  );

  // in_ready is registered so it stays low until the first edge after reset release
  assign accept = u.in_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d   = u.in_a;
          b_d   = u.in_b;
          cnt_d = '0;
          if (legal) begin
            state_d = DRIVE;
            en_d    = en_next;
          end else begin
            state_d = RESP;
            res_d   = '0;
            zero_d  = 1'b1;
            carry_d = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = RESP;
          en_d    = '0;
          res_d   = u.bus;
          zero_d  = (u.bus[DATA_W-1:0] == '0);
          carry_d = u.bus[BUS_W-1];
          err_d   = 1'b0;
        end
      end
      RESP: begin
        if (u.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign u.in_ready   = rdy_q;
  assign u.op_a       = a_q;
  assign u.op_b       = b_q;
  assign u.unit_en    = en_q;
  assign u.out_valid  = (state_q == RESP);
  assign u.out_result = res_q;
  assign u.out_zero   = zero_q;
  assign u.out_carry  = carry_q;
  assign u.out_err    = err_q;

  a_en_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en_q));
  a_en_drive:  assert property (@(posedge clk) disable iff (!rst_n) (en_q != '0) |-> (state_q == DRIVE));
endmodule
